// File: rtl/ext_mem_pkg.sv
// Shared constants and response-stage control bundle
// for the external memory responder.
package ext_mem_pkg;

  localparam logic [4:0] M_XRD = 5'h00;
  localparam logic [4:0] M_XWR = 5'h01;

  localparam logic [1:0] MT_B = 2'd0;
  localparam logic [1:0] MT_H = 2'd1;
  localparam logic [1:0] MT_W = 2'd2;
  localparam logic [1:0] MT_D = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] cmd;
    logic [1:0] size;
    logic       has_data;
  } resp_ctl_t;

endpackage

// File: rtl/ext_mem_sram.sv
// Word array with combinational read and byte-lane
// masked synchronous write; never cleared by reset.
module ext_mem_sram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic                  clk,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // write only the enabled byte lanes
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ext_mem_pipe.sv
// RoCC-style memory responder: accept, align/extend,
// fixed-latency response pipe, stall and statistics.
import ext_mem_pkg::*;

module ext_mem_pipe #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 40,
  parameter int TAG_W        = 8,
  parameter int DEPTH        = 4096,
  parameter int LATENCY      = 2,
  parameter int STALL_PERIOD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic              mem_req_ready,
  input  logic              mem_req_valid,
  input  logic [ADDR_W-1:0] mem_req_bits_addr,
  input  logic [TAG_W-1:0]  mem_req_bits_tag,
  input  logic [4:0]        mem_req_bits_cmd,
  input  logic [1:0]        mem_req_bits_size,
  input  logic              mem_req_bits_signed,
  input  logic [DATA_W-1:0] mem_req_bits_data,
  output logic              mem_resp_valid,
  output logic [ADDR_W-1:0] mem_resp_bits_addr,
  output logic [TAG_W-1:0]  mem_resp_bits_tag,
  output logic [4:0]        mem_resp_bits_cmd,
  output logic [1:0]        mem_resp_bits_size,
  output logic [DATA_W-1:0] mem_resp_bits_data,
  output logic              mem_resp_bits_has_data,
  output logic              err,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    resp_ctl_t         ctl;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic [31:0]       pcnt;
  logic              pstall;
  logic              fire;
  logic [ADDR_W-1:0] widx;
  logic [LB-1:0]     off;
  int                offi;
  int                nbytes;
  int                nbits;
  logic              is_ld;
  logic              is_st;
  logic              bad;
  logic              ok;
  logic [BYTES-1:0]  wbe;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ld;
  resp_t             nxt;
  resp_t             pipe [LATENCY];

  assign pstall = (STALL_PERIOD != 0) &&
                  (pcnt == 32'(STALL_PERIOD - 1));
  assign mem_req_ready = !reset && !stall && !pstall;
  assign fire = mem_req_valid && mem_req_ready;
  assign widx = mem_req_bits_addr >> LB;
  assign off  = mem_req_bits_addr[LB-1:0];

  // free-running phase counter for periodic ready drops
  always_ff @(posedge clk) begin
    if (reset || STALL_PERIOD == 0) begin
      pcnt <= '0;
    end else if (pstall) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 32'd1;
    end
  end

  // classify the request and flag any error condition
  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    bad    = 1'b0;
    offi   = int'(off);
    nbytes = 1 << mem_req_bits_size;
    nbits  = 8 << mem_req_bits_size;
    unique case (1'b1)
      mem_req_bits_cmd == M_XRD: is_ld = 1'b1;
      mem_req_bits_cmd == M_XWR: is_st = 1'b1;
      default:                   bad   = 1'b1;
    endcase
    if ((offi & (nbytes - 1)) != 0) bad = 1'b1;
    if (nbytes > BYTES) bad = 1'b1;
    if (widx >= ADDR_W'(DEPTH)) bad = 1'b1;
    ok = fire && !bad;
  end

  // place store data on its byte lanes
  always_comb begin
    wbe   = '0;
    wdata = mem_req_bits_data << (offi * 8);
    for (int b = 0; b < BYTES; b++) begin
      wbe[b] = ok && is_st &&
               (b >= offi) && (b < offi + nbytes);
    end
  end

  ext_mem_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) sram (
    .clk   (clk),
    .raddr (widx[AW-1:0]),
    .rdata (rdata),
    .we    (ok && is_st),
    .waddr (widx[AW-1:0]),
    .wbe   (wbe),
    .wdata (wdata)
  );

  // shift the lane down, then sign- or zero-extend
  always_comb begin
    sh = rdata >> (offi * 8);
    ld = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits) begin
        ld[i] = sh[i];
      end else begin
        ld[i] = mem_req_bits_signed && sh[nbits-1];
      end
    end
  end

  // build the response entry for the first pipe stage
  always_comb begin
    nxt = '0;
    if (ok) begin
      nxt.ctl.valid    = 1'b1;
      nxt.ctl.cmd      = mem_req_bits_cmd;
      nxt.ctl.size     = mem_req_bits_size;
      nxt.ctl.has_data = is_ld;
      nxt.addr         = mem_req_bits_addr;
      nxt.tag          = mem_req_bits_tag;
      nxt.data         = is_ld ? ld : '0;
    end
  end

  // fixed-latency response pipe; reset drops in-flight entries
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= nxt;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // sticky error flag and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      err         <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (fire && bad) err <= 1'b1;
      if (ok && is_ld && load_count != '1)
        load_count <= load_count + 32'd1;
      if (ok && is_st && store_count != '1)
        store_count <= store_count + 32'd1;
    end
  end

  assign mem_resp_valid         = pipe[LATENCY-1].ctl.valid;
  assign mem_resp_bits_addr     = pipe[LATENCY-1].addr;
  assign mem_resp_bits_tag      = pipe[LATENCY-1].tag;
  assign mem_resp_bits_cmd      = pipe[LATENCY-1].ctl.cmd;
  assign mem_resp_bits_size     = pipe[LATENCY-1].ctl.size;
  assign mem_resp_bits_data     = pipe[LATENCY-1].data;
  assign mem_resp_bits_has_data = pipe[LATENCY-1].ctl.has_data;

endmodule
